// File: rtl/rom_fetch_ctrl_pkg.sv
// rom_fetch_ctrl_pkg: shared FSM state encoding and default sizes for the ROM fetch sequencer
package rom_fetch_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    HOLD    = 3'd4
  } state_t;
  localparam int ADDR_W_DEF       = 8;
  localparam int DATA_W_DEF       = 16;
  localparam int WAIT_TIMEOUT_DEF = 31;
endpackage

// File: rtl/rom_fetch_ctrl_watchdog.sv
// fetch_watchdog: clearable cycle counter; tc flags LIMIT cycles since the last clear
//   Clk, Resetn : clock, async active-low reset
//   clr         : restart counting from zero
//   tc          : counter has reached LIMIT
module fetch_watchdog
  import rom_fetch_ctrl_pkg::*;
#(
  parameter int LIMIT = WAIT_TIMEOUT_DEF
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic clr,
  output logic tc
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge Clk or negedge Resetn)
    if (!Resetn) cnt <= '0;
    else cnt <= clr ? '0 : cnt + 1'b1;
  assign tc = cnt == CW'(LIMIT);
endmodule

// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: instruction-fetch sequencer driving a ROM access timer and a valid/ready decoder port
//   Clk, Resetn          : clock, async active-low reset
//   run                  : keep fetching while high
//   pc_load, pc_load_val : one-cycle PC redirect and its target
//   start_timer, ROMsel  : access request pulse / access window from the timer
//   rom_addr, rom_data   : ROM address (held through the window) and read data
//   instr, instr_valid, instr_ready : decoder handshake
//   pc                   : next fetch address
//   timeout_err          : sticky watchdog error, blocks further fetches until reset
module rom_fetch_ctrl
  import rom_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              run,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              start_timer,
  input  logic              ROMsel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              timeout_err
);
  state_t state, state_n;
  logic [ADDR_W-1:0] pc_n, tgt, tgt_n;
  logic pend, pend_n, valid_n, capture, timeout, tc, waiting;
  assign waiting = state == WAIT_HI || state == WAIT_LO;
  fetch_watchdog #(.LIMIT(WAIT_TIMEOUT)) u_wdog (
    .Clk    (Clk),
    .Resetn (Resetn),
    .clr    (!waiting || state_n != state),
    .tc     (tc)
  );
  always_comb begin
    state_n = state;
    pc_n    = pc;
    pend_n  = pend;
    tgt_n   = tgt;
    valid_n = instr_valid;
    capture = 1'b0;
    timeout = 1'b0;
    // mid-access redirects are deferred; the latest target wins
    if (pc_load && (state == REQ || waiting)) begin
      pend_n = 1'b1;
      tgt_n  = pc_load_val;
    end
    case (state)
      IDLE: begin
        pc_n    = pc_load ? pc_load_val : pc;
        state_n = run && !timeout_err ? REQ : IDLE;
      end
      REQ: state_n = WAIT_HI;
      WAIT_HI: begin
        state_n = ROMsel ? WAIT_LO : state;
        timeout = !ROMsel && tc;
      end
      WAIT_LO: begin
        timeout = ROMsel && tc;
        if (!ROMsel) begin
          // a redirect seen during the access (even this cycle) drops the fetched word
          if (pend || pc_load) begin
            pc_n    = pc_load ? pc_load_val : tgt;
            pend_n  = 1'b0;
            state_n = run ? REQ : IDLE;
          end else begin
            capture = 1'b1;
            valid_n = 1'b1;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        // redirect flushes the held word and beats a same-cycle accept
        if (pc_load || instr_ready) begin
          pc_n    = pc_load ? pc_load_val : pc + 1'b1;
          valid_n = 1'b0;
          state_n = run ? REQ : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (timeout) state_n = IDLE;
  end
  always_ff @(posedge Clk or negedge Resetn)
    if (!Resetn) begin
      state       <= IDLE;
      pc          <= '0;
      rom_addr    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      start_timer <= 1'b0;
      timeout_err <= 1'b0;
      pend        <= 1'b0;
      tgt         <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend        <= pend_n;
      tgt         <= tgt_n;
      instr_valid <= valid_n;
      start_timer <= state_n == REQ;
      if (state_n == REQ) rom_addr <= pc_n;
      if (capture) instr <= rom_data;
      if (timeout) timeout_err <= 1'b1;
    end
endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// tb_rom_fetch_ctrl: directed scenarios plus randomized traffic checked against a transaction-level fetch model
module tb_rom_fetch_ctrl;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int WT = 31;
  logic Clk = 1'b0, Resetn = 1'b0, run = 1'b0, pc_load = 1'b0, ROMsel = 1'b0, instr_ready = 1'b0;
  logic [AW-1:0] pc_load_val = '0, rom_addr, pc;
  logic [DW-1:0] rom_data, instr;
  logic start_timer, instr_valid, timeout_err;
  logic [DW-1:0] rom [256];
  int checks = 0, errors = 0;
  int t_dly = 1, t_win = 13;
  bit dead = 1'b0;
  assign rom_data = rom[rom_addr];
  always #5 Clk = ~Clk;
  rom_fetch_ctrl dut (
    .Clk         (Clk),
    .Resetn      (Resetn),
    .run         (run),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .start_timer (start_timer),
    .ROMsel      (ROMsel),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .timeout_err (timeout_err)
  );
  // timer model: window opens t_dly cycles after the request and stays open t_win cycles
  initial forever begin
    @(negedge Clk);
    if (start_timer === 1'b1 && !dead) begin
      repeat (t_dly) @(negedge Clk);
      ROMsel = 1'b1;
      repeat (t_win) @(negedge Clk);
      ROMsel = 1'b0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic wait_start(input string tag);
    int n = 0;
    while (start_timer !== 1'b1 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (n == 200) chk(tag, start_timer, 1);
  endtask
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (instr_valid !== 1'b1 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (n == 200) chk(tag, instr_valid, 1);
  endtask
  task automatic accept();
    instr_ready = 1'b1;
    @(negedge Clk);
    instr_ready = 1'b0;
  endtask
  initial begin
    int n, cnt;
    bit saw;
    logic [AW-1:0] exp_addr, acc_addr;
    bit acc_redir, v_prev, prev_run, st, v;
    int delivered;
    for (int i = 0; i < 256; i++) rom[i] = DW'($urandom);
    rom[0] = 16'hA5C3;
    repeat (3) @(negedge Clk);
    chk("rst_pc", pc, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_start", start_timer, 0);
    chk("rst_err", timeout_err, 0);
    // basic fetch from address 0
    Resetn = 1'b1;
    run = 1'b1;
    wait_start("t1_start_to");
    chk("t1_addr0", rom_addr, 0);
    n = 0;
    while (instr_valid !== 1'b1 && n < 100) begin
      @(negedge Clk);
      n++;
      if (instr_valid !== 1'b1) begin
        chk("t1_addr_hold", rom_addr, 0);
        chk("t1_one_pulse", start_timer, 0);
      end
    end
    chk("t1_latency", n, t_dly + t_win + 1);
    chk("t1_instr", instr, 16'hA5C3);
    chk("t1_pc", pc, 0);
    // decoder stalls for 10 cycles
    repeat (10) begin
      @(negedge Clk);
      chk("t2_valid", instr_valid, 1);
      chk("t2_instr", instr, 16'hA5C3);
      chk("t2_nostart", start_timer, 0);
    end
    accept();
    chk("t2_pc", pc, 1);
    chk("t2_valid0", instr_valid, 0);
    chk("t2_start", start_timer, 1);
    chk("t2_addr", rom_addr, 1);
    // redirect beats a same-cycle accept
    wait_valid("t5_valid_to", n);
    chk("t5_instr1", instr, rom[1]);
    pc_load = 1'b1;
    pc_load_val = 8'h10;
    instr_ready = 1'b1;
    @(negedge Clk);
    pc_load = 1'b0;
    instr_ready = 1'b0;
    chk("t5_pc", pc, 8'h10);
    chk("t5_flush", instr_valid, 0);
    chk("t5_start", start_timer, 1);
    chk("t5_addr", rom_addr, 8'h10);
    wait_valid("t5_valid2_to", n);
    chk("t5_instr10", instr, rom[8'h10]);
    // pc wrap from 0xFF
    pc_load = 1'b1;
    pc_load_val = 8'hFF;
    @(negedge Clk);
    pc_load = 1'b0;
    chk("t3_start", start_timer, 1);
    chk("t3_addrff", rom_addr, 8'hFF);
    wait_valid("t3_valid_to", n);
    chk("t3_instrff", instr, rom[8'hFF]);
    accept();
    chk("t3_pcwrap", pc, 0);
    chk("t3_start2", start_timer, 1);
    chk("t3_addrwrap", rom_addr, 0);
    // redirect during WAIT_LO discards the fetched word
    repeat (4) @(negedge Clk);
    pc_load = 1'b1;
    pc_load_val = 8'h40;
    @(negedge Clk);
    pc_load = 1'b0;
    n = 0;
    saw = 1'b0;
    while (start_timer !== 1'b1 && n < 100) begin
      if (instr_valid === 1'b1) saw = 1'b1;
      @(negedge Clk);
      n++;
    end
    chk("t4_discard", saw, 0);
    chk("t4_start", start_timer, 1);
    chk("t4_addr", rom_addr, 8'h40);
    chk("t4_pc", pc, 8'h40);
    wait_valid("t4_valid_to", n);
    chk("t4_instr", instr, rom[8'h40]);
    accept();
    chk("t4_pc_inc", pc, 8'h41);
    // run drops mid-access: access completes, nothing new starts
    run = 1'b0;
    wait_valid("t6_valid_to", n);
    chk("t6_instr", instr, rom[8'h41]);
    accept();
    chk("t6_pc", pc, 8'h42);
    cnt = 0;
    repeat (20) begin
      @(negedge Clk);
      if (start_timer === 1'b1) cnt++;
    end
    chk("t6_nostart", cnt, 0);
    // reset in the middle of an access
    run = 1'b1;
    wait_start("t7_start_to");
    chk("t7_addr", rom_addr, 8'h42);
    repeat (5) @(negedge Clk);
    Resetn = 1'b0;
    #1;
    chk("t7_pc", pc, 0);
    chk("t7_addr0", rom_addr, 0);
    chk("t7_valid", instr_valid, 0);
    chk("t7_start", start_timer, 0);
    repeat (t_dly + t_win + 3) @(negedge Clk);
    Resetn = 1'b1;
    wait_start("t7_restart_to");
    chk("t7_readdr", rom_addr, 0);
    wait_valid("t7_valid_to", n);
    chk("t7_instr", instr, rom[0]);
    dead = 1'b1;
    // timer never answers: error after WAIT_TIMEOUT+1 cycles in WAIT_HI
    accept();
    chk("t8_start", start_timer, 1);
    n = 0;
    while (timeout_err !== 1'b1 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("t8_latency", n, WT + 2);
    chk("t8_valid", instr_valid, 0);
    cnt = 0;
    repeat (40) begin
      @(negedge Clk);
      if (start_timer === 1'b1) cnt++;
    end
    chk("t8_nostart", cnt, 0);
    pc_load = 1'b1;
    pc_load_val = 8'h05;
    @(negedge Clk);
    pc_load = 1'b0;
    chk("t8_pcload", pc, 8'h05);
    chk("t8_sticky", timeout_err, 1);
    Resetn = 1'b0;
    dead = 1'b0;
    @(negedge Clk);
    chk("t8_clear", timeout_err, 0);
    // window stuck open: watchdog fires in WAIT_LO
    t_win = 40;
    Resetn = 1'b1;
    wait_start("t9_start_to");
    n = 0;
    while (timeout_err !== 1'b1 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("t9_latency", n, t_dly + WT + 2);
    chk("t9_valid", instr_valid, 0);
    Resetn = 1'b0;
    repeat (45) @(negedge Clk);
    // randomized traffic against a transaction-level model
    exp_addr = '0;
    acc_addr = '0;
    acc_redir = 1'b0;
    v_prev = 1'b0;
    prev_run = 1'b1;
    delivered = 0;
    Resetn = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      st = start_timer;
      v = instr_valid;
      if (st) begin
        chk("r_addr", rom_addr, exp_addr);
        chk("r_pc", pc, exp_addr);
        chk("r_run", prev_run, 1);
        acc_addr = exp_addr;
        acc_redir = 1'b0;
      end
      if (v && !v_prev) begin
        chk("r_redir", acc_redir, 0);
        chk("r_instr", instr, rom[acc_addr]);
        chk("r_hold_pc", pc, acc_addr);
        delivered++;
      end else if (v) chk("r_stable", instr, rom[acc_addr]);
      v_prev = v;
      t_dly = $urandom_range(1, 3);
      t_win = $urandom_range(1, 15);
      run = $urandom_range(0, 19) != 0;
      instr_ready = $urandom_range(0, 2) == 0;
      pc_load = $urandom_range(0, 24) == 0;
      pc_load_val = AW'($urandom);
      if (pc_load) begin
        exp_addr = pc_load_val;
        if (!v) acc_redir = 1'b1;
      end else if (v && instr_ready) exp_addr = acc_addr + 1'b1;
      prev_run = run;
    end
    chk("r_progress", delivered > 50, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
